// File: rtl/btn_event_gen.sv
// btn_event_gen
// Multi-channel push-button conditioning. Each raw level is synchronised,
// debounced, and turned into one-cycle press / release / auto-repeat pulses
// so the downstream controller only ever sees clean single-cycle events.
//
// Per-channel FSM:
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   IDLE       | button released and stable, level 0
//   DEB_PRESS  | synchronised input high, counting out the press debounce
//   HELD       | press accepted, level 1, counting towards the first repeat
//   REPEAT     | auto-repeating, one pulse every REPEAT_PERIOD cycles
//   DEB_REL    | synchronised input low, counting out the release debounce
//
// Every counter stops at a terminal compare, so none of them can wrap.

module btn_event_gen #(
    parameter int NUM_BTN         = 4,
    parameter int CNT_W           = 24,
    parameter int DEBOUNCE_CYCLES = 512,
    parameter int REPEAT_DELAY    = 5_000_000,
    parameter int REPEAT_PERIOD   = 2_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_BTN-1:0] repeat_en,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat,
    output logic [NUM_BTN-1:0] btn_event
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEB_PRESS = 3'd1,
        ST_HELD      = 3'd2,
        ST_REPEAT    = 3'd3,
        ST_DEB_REL   = 3'd4
    } state_t;

    // Terminal counts; a phase of N cycles ends when cnt reaches N-1.
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST   = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [NUM_BTN-1:0] sync_1;
    logic [NUM_BTN-1:0] sync_2;

    // Two-flop synchroniser for the asynchronous button levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             level_q;
        logic             press_q;
        logic             rel_q;
        logic             rep_q;
        logic             event_q;
        logic             s;

        assign s = sync_2[i];

        // Channel FSM with registered level and pulse outputs; pulses
        // default low every cycle and are raised only on the causing edge.
        always_ff @(posedge clk) begin
            if (reset) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                rep_q   <= 1'b0;
                event_q <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                rep_q   <= 1'b0;
                event_q <= 1'b0;

                case (state)
                    ST_IDLE: begin
                        level_q <= 1'b0;
                        if (s) begin
                            state <= ST_DEB_PRESS;
                            cnt   <= '0;
                        end
                    end

                    ST_DEB_PRESS: begin
                        if (!s) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else if (cnt == DEB_LAST) begin
                            state   <= ST_HELD;
                            cnt     <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                            event_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    ST_HELD: begin
                        if (!s) begin
                            state <= ST_DEB_REL;
                            cnt   <= '0;
                        end else if (!repeat_en[i]) begin
                            cnt <= '0;
                        end else if (cnt == DELAY_LAST) begin
                            state   <= ST_REPEAT;
                            cnt     <= '0;
                            rep_q   <= 1'b1;
                            event_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    ST_REPEAT: begin
                        if (!s) begin
                            state <= ST_DEB_REL;
                            cnt   <= '0;
                        end else if (!repeat_en[i]) begin
                            state <= ST_HELD;
                            cnt   <= '0;
                        end else if (cnt == PER_LAST) begin
                            cnt     <= '0;
                            rep_q   <= 1'b1;
                            event_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    ST_DEB_REL: begin
                        // A return to high here is bounce: go back to HELD
                        // and restart the repeat delay from scratch.
                        if (s) begin
                            state <= ST_HELD;
                            cnt   <= '0;
                        end else if (cnt == DEB_LAST) begin
                            state   <= ST_IDLE;
                            cnt     <= '0;
                            level_q <= 1'b0;
                            rel_q   <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    default: begin
                        state   <= ST_IDLE;
                        cnt     <= '0;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = rel_q;
        assign btn_repeat[i]  = rep_q;
        assign btn_event[i]   = event_q;
    end

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen with short timing parameters
// (debounce 4, repeat delay 10, repeat period 5).

module tb_btn_event_gen;

    localparam int NB = 4;

    logic          clk;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] repeat_en;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_repeat;
    logic [NB-1:0] btn_event;

    int n_checks = 0;
    int n_fail   = 0;

    btn_event_gen #(
        .NUM_BTN        (NB),
        .CNT_W          (24),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .repeat_en  (repeat_en),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat),
        .btn_event  (btn_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [NB-1:0] acc_rep;
    logic          exp_bit;

    initial begin
        reset     = 1'b1;
        btn_raw   = '0;
        repeat_en = 4'b0001;

        // Reset held for two edges.
        tick(2);
        check("rst_level",   btn_level,   4'h0);
        check("rst_press",   btn_press,   4'h0);
        check("rst_release", btn_release, 4'h0);
        check("rst_repeat",  btn_repeat,  4'h0);
        check("rst_event",   btn_event,   4'h0);

        // Raw[0] high sampled at edge 3: press after edge 9.
        reset   = 1'b0;
        btn_raw = 4'b0001;
        tick(6);
        check("press_early", btn_press, 4'h0);
        check("level_early", btn_level, 4'h0);
        tick(1);
        check("press_0", btn_press, 4'b0001);
        check("level_0", btn_level, 4'b0001);
        check("event_0", btn_event, 4'b0001);
        tick(1);
        check("press_1cyc", btn_press, 4'h0);
        check("level_hold", btn_level, 4'b0001);

        // Hold 40 cycles after the press; repeats at +10, +15, ...
        // A 3-cycle glitch on channel 1 runs alongside.
        for (int t = 2; t <= 40; t++) begin
            tick(1);
            exp_bit = (t >= 10 && ((t - 10) % 5) == 0);
            check("hold_repeat", btn_repeat, {3'b000, exp_bit});
            check("hold_event",  btn_event,  {3'b000, exp_bit});
            check("hold_press",  btn_press,  4'h0);
            check("hold_level",  btn_level,  4'b0001);
            if (t == 2) btn_raw[1] = 1'b1;
            if (t == 5) btn_raw[1] = 1'b0;
        end

        // Two-cycle bounce low on channel 0: no release, repeat delay restarts.
        btn_raw[0] = 1'b0;
        for (int u = 1; u <= 16; u++) begin
            tick(1);
            check("bounce_release", btn_release, 4'h0);
            check("bounce_level",   btn_level,   4'b0001);
            check("bounce_repeat",  btn_repeat,  (u == 15) ? 4'b0001 : 4'h0);
            if (u == 2) btn_raw[0] = 1'b1;
        end

        // Real release: single pulse 7 edges after raw goes low.
        btn_raw[0] = 1'b0;
        for (int v = 1; v <= 9; v++) begin
            tick(1);
            check("rel_pulse",  btn_release, (v == 7) ? 4'b0001 : 4'h0);
            check("rel_level",  btn_level,   (v < 7) ? 4'b0001 : 4'h0);
            check("rel_repeat", btn_repeat,  4'h0);
            check("rel_press",  btn_press,   4'h0);
        end

        // Re-press, reach REPEAT, then reset mid-repeat.
        btn_raw[0] = 1'b1;
        tick(7);
        check("repress", btn_press, 4'b0001);
        tick(10);
        check("repress_repeat", btn_repeat, 4'b0001);
        tick(2);
        reset = 1'b1;
        tick(1);
        check("midrst_level",   btn_level,   4'h0);
        check("midrst_press",   btn_press,   4'h0);
        check("midrst_release", btn_release, 4'h0);
        check("midrst_repeat",  btn_repeat,  4'h0);
        check("midrst_event",   btn_event,   4'h0);
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            check("postrst_release", btn_release, 4'h0);
            check("postrst_press",   btn_press, (i == 7) ? 4'b0001 : 4'h0);
            check("postrst_level",   btn_level, (i == 7) ? 4'b0001 : 4'h0);
        end

        // Let channel 0 release back to idle.
        btn_raw = '0;
        tick(12);
        check("idle_level", btn_level, 4'h0);

        // All channels pressed on one edge with repeat disabled.
        repeat_en = '0;
        btn_raw   = 4'hF;
        tick(6);
        check("all_press_early", btn_press, 4'h0);
        tick(1);
        check("all_press", btn_press, 4'hF);
        check("all_event", btn_event, 4'hF);
        check("all_level", btn_level, 4'hF);
        acc_rep = '0;
        for (int j = 0; j < 30; j++) begin
            tick(1);
            acc_rep = acc_rep | btn_repeat;
        end
        check("all_no_repeat", acc_rep, 4'h0);
        check("all_level_end", btn_level, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
